lt_uint_serial_msb: RTL
=======================

Name: lt_uint_serial_msb

Overview:
- Sequential, bit-serial unsigned magnitude comparator.
- Scans operands MSB-first, BITS_PER_CYCLE bits per cycle, and returns a one-hot lt/eq/gt result with a start/done handshake.
- Area-lean counterpart to the combinational LSB-first borrow-chain comparator; used in PIM control paths where a WIDTH-deep ripple is too long and latency is tolerable.
- Optional early exit at the first differing chunk.

Parameters:
- WIDTH, 32, operand width in bits; must be ≥1.
- BITS_PER_CYCLE, 1, bits compared per SCAN cycle; must divide WIDTH.
- EARLY_EXIT, 1, 1 = finish at first differing chunk; 0 = always scan all chunks (constant time).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only when busy=0.
- A  input  WIDTH  operand A; captured on accepted start.
- B  input  WIDTH  operand B; captured on accepted start.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse; result valid.
- lt  output  1  A < B (unsigned).
- eq  output  1  A == B.
- gt  output  1  A > B (unsigned).
- cycles  output  $clog2(NCHUNK)+1  number of SCAN cycles used by the last operation.

Behaviour:
- NCHUNK = WIDTH/BITS_PER_CYCLE. Chunk k covers bits [(k+1)*BPC-1 : k*BPC].
- States:
  - IDLE: busy=0, done=0.
  - SCAN: busy=1.
  - DONE: busy=0, done=1, one cycle only.
- Reset (rst=1 at an edge), regardless of state:
  - state ← IDLE.
  - busy, done, lt, eq, gt, cycles ← 0.
  - operand registers ← 0.
  - Any in-flight scan is abandoned with no done pulse.
- Accept: start=1 at an edge with state IDLE or DONE.
  - Latch A and B.
  - Set chunk index ← NCHUNK-1, decided ← 0, cycle counter ← 0.
  - Enter SCAN.
  - lt/eq/gt/cycles keep their previous values until the new result is written.
  - start while in SCAN is ignored; it is not queued.
- Each SCAN cycle compares chunk[index] of the latched operands, and the counter increments.
  - First chunk with A≠B sets decided=1 and captures the sign: gt if A-chunk > B-chunk, else lt.
- Completion edge (state → DONE):
  - EARLY_EXIT=1: at the edge ending the first differing chunk, or the edge ending chunk 0.
  - EARLY_EXIT=0: always at the edge ending chunk 0; chunks after the decision do not alter it.
- On the completion edge:
  - Write exactly one of lt/eq/gt as 1 (eq only if no chunk differed).
  - Write cycles = SCAN cycles used, in 1..NCHUNK.
- Latency:
  - Accept edge E0 → done high after edge E_cycles.
  - Worst case NCHUNK cycles; best case (early exit on MSB chunk) 1 cycle.
- DONE → IDLE on the next edge unless start=1, in which case DONE → SCAN (back-to-back; done still pulses for exactly one cycle).
- Result hold: lt/eq/gt/cycles hold from the completion edge until the next completion or reset.
- One-hot invariant: lt+eq+gt ≤ 1 at all times; 0 only after reset before the first completion.
- Width rules: pure unsigned, no sign extension. WIDTH=1 with BPC=1 gives NCHUNK=1.
- Elaboration: WIDTH % BITS_PER_CYCLE ≠ 0 is an error.

Decomposition:
- Shared package lt_serial_pkg:
  - state enum {IDLE, SCAN, DONE}.
  - Function computing NCHUNK and counter width from WIDTH/BITS_PER_CYCLE.
- Sub-module cmp_chunk_msb, parameter BITS_PER_CYCLE:
  - Combinational chunk comparator.
  - Inputs a_chunk and b_chunk; outputs c_lt and c_gt.
  - Instantiated once and fed by an index-selected slice.
- The top holds the FSM, operand registers, index and cycle counters, and the result registers.

Test Plan:
1. WIDTH=8, BPC=1, EARLY_EXIT=1; A=0x80, B=0x7F, start pulse → gt=1, lt=eq=0, cycles=1; done high exactly 1 cycle after the accept edge; busy high 1 cycle.
2. Same config; A=B=0xA5 → eq=1, cycles=8; done 8 cycles after accept; busy high for 8 cycles.
3. Same config; A=0x12, B=0x13 → lt=1, cycles=8 (difference only at bit 0). Assert start again during SCAN with A=0xFF, B=0x00 → ignored; the result is still lt.
4. EARLY_EXIT=0; A=0x80, B=0x00 → gt=1, cycles=8; the result is unchanged by the later equal chunks.
5. BPC=4, WIDTH=8:
   - A=0x3C, B=0x3D → lt=1, cycles=2.
   - Then start=1 during the DONE cycle with A=0x40, B=0x3F → accepted back-to-back; gt=1, cycles=1; two separate single-cycle done pulses.
6. WIDTH=8, BPC=1; start A=0x01, B=0x02, assert rst at the 3rd SCAN cycle → next cycle busy=done=lt=eq=gt=cycles=0, state IDLE, no done pulse. A fresh start with A=0x02, B=0x01 then yields gt=1, cycles=7.

Source files
------------

// File: rtl/lt_serial_pkg.sv
// ----------------------------------------------------------------------------
// lt_serial_pkg
//
// Shared definitions for the bit-serial MSB-first unsigned comparator.
//   state_t         : controller states (IDLE, SCAN, DONE)
//   calc_nchunk     : number of BITS_PER_CYCLE-wide chunks in a WIDTH operand
//   calc_cnt_width  : width of the chunk index / cycle counter / cycles port
// ----------------------------------------------------------------------------
package lt_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Guarded against a zero divisor so that a bad parameter set reaches the
  // elaboration check in the top instead of failing inside this function.
  function automatic int calc_nchunk(input int width, input int bpc);
    return (bpc > 0) ? (width / bpc) : 1;
  endfunction

  // One extra bit over $clog2 so the counter can hold NCHUNK itself
  // (and so NCHUNK=1 still yields a 1-bit, non-empty vector).
  function automatic int calc_cnt_width(input int width, input int bpc);
    return $clog2(calc_nchunk(width, bpc)) + 1;
  endfunction

endpackage

// File: rtl/cmp_chunk_msb.sv
// ----------------------------------------------------------------------------
// cmp_chunk_msb
//
// Combinational unsigned compare of one BITS_PER_CYCLE-wide chunk.
//   a_chunk, b_chunk : chunk of operand A / operand B
//   c_lt             : a_chunk <  b_chunk
//   c_gt             : a_chunk >  b_chunk
// Both low means the chunks are equal.
// ----------------------------------------------------------------------------
module cmp_chunk_msb #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [BITS_PER_CYCLE-1:0] a_chunk,
  input  logic [BITS_PER_CYCLE-1:0] b_chunk,
  output logic                      c_lt,
  output logic                      c_gt
);

  assign c_lt = (a_chunk < b_chunk);
  assign c_gt = (a_chunk > b_chunk);

endmodule

// File: rtl/lt_uint_serial_msb.sv
// ----------------------------------------------------------------------------
// lt_uint_serial_msb
//
// Bit-serial unsigned magnitude comparator. Operands are latched on an
// accepted start and scanned MSB chunk first, BITS_PER_CYCLE bits per cycle.
// The first differing chunk decides the result; with EARLY_EXIT=1 the scan
// stops there, with EARLY_EXIT=0 it always runs all chunks (constant time).
//
// Ports
//   clk    : clock, rising edge
//   rst    : synchronous, active-high reset
//   start  : request, honoured when busy=0 (IDLE or DONE)
//   A, B   : operands, captured on an accepted start
//   busy   : high while scanning
//   done   : one-cycle pulse, result valid
//   lt/eq/gt : one-hot result, held until the next completion or reset
//   cycles : scan cycles used by the last completed compare (1..NCHUNK)
// ----------------------------------------------------------------------------
module lt_uint_serial_msb
  import lt_serial_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int EARLY_EXIT     = 1
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               start,
  input  logic [WIDTH-1:0]                                   A,
  input  logic [WIDTH-1:0]                                   B,
  output logic                                               busy,
  output logic                                               done,
  output logic                                               lt,
  output logic                                               eq,
  output logic                                               gt,
  output logic [calc_cnt_width(WIDTH, BITS_PER_CYCLE)-1:0]   cycles
);

  localparam int NCHUNK = calc_nchunk(WIDTH, BITS_PER_CYCLE);
  localparam int CW     = calc_cnt_width(WIDTH, BITS_PER_CYCLE);

  if (WIDTH < 1 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
    $error("lt_uint_serial_msb: WIDTH must be >= 1 and a multiple of BITS_PER_CYCLE");
  end

  state_t state_q, state_d;

  logic [WIDTH-1:0]          a_q, b_q;
  logic [CW-1:0]             idx_q;      // chunk currently being compared
  logic [CW-1:0]             cnt_q;      // scan cycles spent so far
  logic                      decided_q;  // an earlier chunk already differed
  logic                      sign_gt_q;  // direction captured at that chunk
  logic                      lt_q, eq_q, gt_q;
  logic [CW-1:0]             cycles_q;

  logic [BITS_PER_CYCLE-1:0] a_chunk, b_chunk;
  logic                      c_lt, c_gt;
  logic                      chunk_differs;
  logic                      last_chunk;
  logic                      accept;
  logic                      finish;
  logic                      decided_now;
  logic                      gt_now;

  // Chunk select written as a mux over constant slices so every slice
  // index is a compile-time constant.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first;
    // a path that leaves one unassigned would infer a latch.
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx_q == CW'(k)) begin
        a_chunk = a_q[k*BITS_PER_CYCLE +: BITS_PER_CYCLE];
        b_chunk = b_q[k*BITS_PER_CYCLE +: BITS_PER_CYCLE];
      end
    end
  end

  cmp_chunk_msb #(
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_cmp (
    .a_chunk (a_chunk),
    .b_chunk (b_chunk),
    .c_lt    (c_lt),
    .c_gt    (c_gt)
  );

  assign chunk_differs = c_lt | c_gt;
  assign last_chunk    = (idx_q == '0);
  assign accept        = start && (state_q != SCAN);

  // Once decided, later chunks never change the direction; otherwise the
  // current chunk supplies it.
  assign decided_now   = decided_q | chunk_differs;
  assign gt_now        = decided_q ? sign_gt_q : c_gt;

  // Next state and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = SCAN;
      end
      SCAN: begin
        busy   = 1'b1;
        finish = last_chunk ||
                 ((EARLY_EXIT != 0) && !decided_q && chunk_differs);
        if (finish) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = start ? SCAN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      sign_gt_q <= 1'b0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      cycles_q  <= '0;
    end else if (accept) begin
      // Result registers are left alone: the previous answer stays visible
      // until this compare completes.
      a_q       <= A;
      b_q       <= B;
      idx_q     <= CW'(NCHUNK - 1);
      cnt_q     <= '0;
      decided_q <= 1'b0;
      sign_gt_q <= 1'b0;
    end else if (state_q == SCAN) begin
      cnt_q <= cnt_q + CW'(1);
      if (!last_chunk) idx_q <= idx_q - CW'(1);
      if (!decided_q && chunk_differs) begin
        decided_q <= 1'b1;
        sign_gt_q <= c_gt;
      end
      if (finish) begin
        lt_q     <= decided_now & ~gt_now;
        gt_q     <= decided_now &  gt_now;
        eq_q     <= ~decided_now;
        cycles_q <= cnt_q + CW'(1);
      end
    end
  end

  assign lt     = lt_q;
  assign eq     = eq_q;
  assign gt     = gt_q;
  assign cycles = cycles_q;

endmodule
